switch_egress_reader: RTL

Per-port egress stage directly downstream of the switch core's post-processing output queues. It consumes one port's pointer FIFO (frame descriptors) and data FIFO (frame bytes), and replays each frame as a registered byte stream (tx_dv/tx_sof/tx_eof/tx_data) toward the port MAC. It enforces a minimum inter-frame gap and drains malformed descriptors without transmitting them. One instance per port (0..3).

---
 rtl/switch_pkg.sv | 16 +
 rtl/egress_tx_pipe.sv | 55 +++++
 rtl/switch_egress_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared state encoding and frame constants for the switch egress path
package switch_pkg;

   localparam int PTR_LEN_W     = 12;
   localparam int MAX_FRAME_LEN = 1518;
   localparam int MIN_IFG_BYTES = 12;

   typedef enum logic [2:0] {
      EGR_IDLE,
      EGR_LOAD,
      EGR_DATA,
      EGR_DRAIN,
      EGR_IFG
   } egr_state_t;

endpackage

// File: rtl/egress_tx_pipe.sv
// rtl/egress_tx_pipe.sv - two-stage pipe aligning read flags with non-FWFT data and driving the tx byte stream
module egress_tx_pipe (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_rd,
   input  logic       i_first,
   input  logic       i_last,
   input  logic       i_drop,
   input  logic [7:0] i_data,
   output logic       o_tx_dv,
   output logic       o_tx_sof,
   output logic       o_tx_eof,
   output logic [7:0] o_tx_data,
   output logic       o_eof_next
);

   logic r_s1_rd;
   logic r_s1_first;
   logic r_s1_last;
   logic r_s1_drop;
   logic w_s1_send;

   // Stage 1 lines up with the FIFO data, which appears the cycle after the read.
   assign w_s1_send  = r_s1_rd & ~r_s1_drop;
   assign o_eof_next = w_s1_send & r_s1_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_rd    <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_drop  <= 1'b0;
      end else begin
         r_s1_rd    <= i_rd;
         r_s1_first <= i_first;
         r_s1_last  <= i_last;
         r_s1_drop  <= i_drop;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_tx_dv   <= 1'b0;
         o_tx_sof  <= 1'b0;
         o_tx_eof  <= 1'b0;
         o_tx_data <= 8'h00;
      end else begin
         o_tx_dv   <= w_s1_send;
         o_tx_sof  <= w_s1_send & r_s1_first;
         o_tx_eof  <= o_eof_next;
         o_tx_data <= w_s1_send ? i_data : 8'h00;
      end
   end

endmodule

// File: rtl/switch_egress_reader.sv
// rtl/switch_egress_reader.sv - per-port egress reader replaying queued frames as a registered tx byte stream
module switch_egress_reader
   import switch_pkg::*;
#(
   parameter int LEN_W      = PTR_LEN_W,
   parameter int MAX_LEN    = MAX_FRAME_LEN,
   parameter int IFG_CYCLES = MIN_IFG_BYTES - 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             port_en,
   input  logic             ptr_fifo_empty,
   input  logic [15:0]      ptr_fifo_dout,
   output logic             ptr_fifo_rd,
   input  logic [7:0]       data_fifo_dout,
   output logic             data_fifo_rd,
   output logic             tx_dv,
   output logic             tx_sof,
   output logic             tx_eof,
   output logic [7:0]       tx_data,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
   localparam logic [7:0]       IFG_V     = 8'(IFG_CYCLES);

   egr_state_t       r_state;
   egr_state_t       w_next_state;
   logic [LEN_W-1:0] r_remaining;
   logic [7:0]       r_ifg_cnt;
   logic             r_first;
   logic             r_armed;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic [LEN_W-1:0] w_len;
   logic             w_len_zero;
   logic             w_len_big;
   logic             w_bad_desc;
   logic             w_last_rd;
   logic             w_drop;
   logic             w_eof_next;
   logic             w_unused_ptr_hi;

   assign w_len           = ptr_fifo_dout[LEN_W-1:0];
   assign w_unused_ptr_hi = ^ptr_fifo_dout[15:LEN_W];
   assign w_len_zero      = (w_len == '0);
   assign w_len_big       = (w_len > MAX_LEN_V);
   assign w_bad_desc      = w_len_zero | w_len_big;
   assign w_last_rd       = (r_remaining == LEN_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= EGR_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         EGR_IDLE:  if (ptr_fifo_rd) w_next_state = EGR_LOAD;
         EGR_LOAD: begin
            if (w_len_zero)     w_next_state = EGR_IFG;
            else if (w_len_big) w_next_state = EGR_DRAIN;
            else                w_next_state = EGR_DATA;
         end
         EGR_DATA,
         EGR_DRAIN: if (w_last_rd) w_next_state = EGR_IFG;
         EGR_IFG:   if (r_ifg_cnt == 8'd1) w_next_state = EGR_IDLE;
         default:   w_next_state = EGR_IDLE;
      endcase
   end

   // r_armed keeps the pointer pop low while reset is held and for the first cycle after release.
   always_comb begin
      ptr_fifo_rd  = 1'b0;
      data_fifo_rd = 1'b0;
      w_drop       = 1'b0;
      busy         = (r_state != EGR_IDLE);
      case (r_state)
         EGR_IDLE:  ptr_fifo_rd = r_armed & port_en & ~ptr_fifo_empty;
         EGR_DATA:  data_fifo_rd = 1'b1;
         EGR_DRAIN: begin
            data_fifo_rd = 1'b1;
            w_drop       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_remaining <= '0;
         r_ifg_cnt   <= 8'd0;
         r_first     <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            EGR_LOAD: begin
               r_remaining <= w_len;
               r_first     <= 1'b1;
               if (w_len_zero) r_ifg_cnt <= IFG_V;
            end
            EGR_DATA,
            EGR_DRAIN: begin
               r_remaining <= r_remaining - LEN_W'(1);
               r_first     <= 1'b0;
               if (w_last_rd) r_ifg_cnt <= IFG_V;
            end
            EGR_IFG: r_ifg_cnt <= r_ifg_cnt - 8'd1;
            default: ;
         endcase
      end
   end

   // frame_cnt steps on the same edge that raises tx_eof.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_eof_next) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         if ((r_state == EGR_LOAD) && w_bad_desc) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;

   egress_tx_pipe u_tx_pipe (
      .clk        (clk),
      .rstn       (rstn),
      .i_rd       (data_fifo_rd),
      .i_first    (r_first),
      .i_last     (w_last_rd),
      .i_drop     (w_drop),
      .i_data     (data_fifo_dout),
      .o_tx_dv    (tx_dv),
      .o_tx_sof   (tx_sof),
      .o_tx_eof   (tx_eof),
      .o_tx_data  (tx_data),
      .o_eof_next (w_eof_next)
   );

endmodule
